// File: rtl/melody_player_param.sv
// Melody sequencer: walks an external jukebox table note by note, timing notes and gaps in ticks.
// Optional build macro MELODY_PLAYER_LOOP_EN makes loopEn restart the melody at its end.
module melody_player_param #(
    parameter int CLK_PER_TICK = 315000,
    parameter int BEAT_TICKS   = 12,
    parameter int GAP_TICKS    = 3,
    parameter int IDX_W        = 5,
    parameter int LEN_W        = 4,
    parameter int TONE_W       = 4
) (
    input  logic              CLOCK_31p5,
    input  logic              resetN,
    input  logic              startMelodyKey,
    input  logic              stopKey,
    input  logic              pauseKey,
    input  logic              loopEn,
    input  logic [LEN_W-1:0]  note_length,
    input  logic [TONE_W-1:0] tone_in,
    input  logic              silenceN,
    output logic [IDX_W-1:0]  noteIndex,
    output logic [TONE_W-1:0] tone,
    output logic              EnableSoundOut,
    output logic              melodyEnded,
    output logic              busy
);

    localparam int MAX_NOTE = BEAT_TICKS * ((1 << LEN_W) - 1);
    localparam int MAX_CNT  = (MAX_NOTE > GAP_TICKS) ? MAX_NOTE : GAP_TICKS;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);
    localparam int PS_W     = $clog2(CLK_PER_TICK);

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_PER_TICK - 1);
    localparam logic [PS_W-1:0]  PS_ONE   = PS_W'(1);
    localparam logic [CNT_W-1:0] BEAT_C   = CNT_W'(BEAT_TICKS);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        ENDED
    } state_t;

    state_t           state;
    logic [PS_W-1:0]  presc;
    logic [CNT_W-1:0] cnt;
    logic             snd;
    logic             tick;
    logic             loop_active;
    logic             timing;
    logic             cnt_last;

`ifdef MELODY_PLAYER_LOOP_EN
    assign loop_active = loopEn;
`else
    // loopEn stays on the port but can never request a repeat in this build.
    assign loop_active = loopEn & 1'b0;
`endif

    assign tick     = (presc == PS_LAST);
    assign cnt_last = (cnt == CNT_ONE);
    // The prescaler only advances while a note or gap is being timed, so the
    // one-clock LOAD and ENDED states never eat into a note's duration.
    assign timing   = (state == PLAY) || (state == GAP);

    always_ff @(posedge CLOCK_31p5 or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            presc          <= '0;
            cnt            <= '0;
            snd            <= 1'b0;
            noteIndex      <= '0;
            tone           <= '0;
            EnableSoundOut <= 1'b0;
            melodyEnded    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            EnableSoundOut <= 1'b0;
            melodyEnded    <= 1'b0;

            if (stopKey) begin
                state     <= IDLE;
                noteIndex <= '0;
                busy      <= 1'b0;
            end else if (startMelodyKey) begin
                state     <= LOAD;
                noteIndex <= '0;
                presc     <= '0;
                busy      <= 1'b1;
            end else begin
                if (timing) begin
                    presc <= tick ? '0 : presc + PS_ONE;
                end

                case (state)
                    IDLE: begin
                        noteIndex <= '0;
                    end

                    LOAD: begin
                        if (note_length == '0) begin
                            state       <= ENDED;
                            melodyEnded <= 1'b1;
                        end else begin
                            tone           <= tone_in;
                            snd            <= silenceN;
                            cnt            <= BEAT_C * CNT_W'(note_length);
                            EnableSoundOut <= silenceN & ~pauseKey;
                            state          <= PLAY;
                        end
                    end

                    PLAY: begin
                        EnableSoundOut <= snd & ~pauseKey;
                        if (tick && !pauseKey) begin
                            if (cnt_last) begin
                                EnableSoundOut <= 1'b0;
                                // Last table slot: finish rather than wrap the index.
                                if (noteIndex == IDX_LAST) begin
                                    state       <= ENDED;
                                    melodyEnded <= 1'b1;
                                end else begin
                                    noteIndex <= noteIndex + IDX_ONE;
                                    cnt       <= GAP_C;
                                    state     <= GAP;
                                end
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                    end

                    GAP: begin
                        if (tick && !pauseKey) begin
                            if (cnt_last) begin
                                state <= LOAD;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                    end

                    ENDED: begin
                        noteIndex <= '0;
                        busy      <= loop_active;
                        state     <= loop_active ? LOAD : IDLE;
                    end

                    default: begin
                        state     <= IDLE;
                        noteIndex <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
